// File: rtl/onchip_mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port s1 between two Avalon-MM requesters.
// After reset the RAM is optionally zero-filled before any requester is granted.
module onchip_mem_port_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 128,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     req0_address,
    input  logic [DATA_W/8-1:0]   req0_byteenable,
    input  logic                  req0_read,
    input  logic                  req0_write,
    input  logic [DATA_W-1:0]     req0_writedata,
    output logic                  req0_waitrequest,
    output logic [DATA_W-1:0]     req0_readdata,
    output logic                  req0_readdatavalid,

    input  logic [ADDR_W-1:0]     req1_address,
    input  logic [DATA_W/8-1:0]   req1_byteenable,
    input  logic                  req1_read,
    input  logic                  req1_write,
    input  logic [DATA_W-1:0]     req1_writedata,
    output logic                  req1_waitrequest,
    output logic [DATA_W-1:0]     req1_readdata,
    output logic                  req1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  init_done
);

    localparam int                BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_INIT, S_ARB} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic              r_rr, w_rr_nxt;
    logic              r_vld_p1, r_id_p1;
    logic              w_vld_p0, w_id_p0;
    logic              w_act0, w_act1, w_gnt0, w_gnt1;

    assign w_act0 = req0_read | req0_write;
    assign w_act1 = req1_read | req1_write;
    // r_rr == 0 favours req0 when both are active.
    assign w_gnt0 = w_act0 & (~w_act1 | ~r_rr);
    assign w_gnt1 = w_act1 & ~w_gnt0;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_init_done_nxt  = r_init_done;
        w_rr_nxt         = r_rr;
        w_vld_p0         = 1'b0;
        w_id_p0          = 1'b0;
        req0_waitrequest = 1'b1;
        req1_waitrequest = 1'b1;
        mem_address      = '0;
        mem_byteenable   = '0;
        mem_chipselect   = 1'b0;
        mem_write        = 1'b0;
        mem_writedata    = '0;

        // Outputs stay in their idle values while reset is held.
        if (reset_n) begin
            case (r_state)
                S_INIT: begin
                    mem_chipselect = 1'b1;
                    mem_write      = 1'b1;
                    mem_address    = r_cnt;
                    mem_byteenable = '1;
                    if (r_cnt == LAST) begin
                        w_state_nxt     = S_ARB;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_ARB: begin
                    if (w_gnt0) begin
                        req0_waitrequest = 1'b0;
                        mem_chipselect   = 1'b1;
                        mem_write        = req0_write;
                        mem_address      = req0_address;
                        mem_byteenable   = req0_byteenable;
                        mem_writedata    = req0_writedata;
                        w_rr_nxt         = 1'b1;
                        w_vld_p0         = ~req0_write;
                        w_id_p0          = 1'b0;
                    end else if (w_gnt1) begin
                        req1_waitrequest = 1'b0;
                        mem_chipselect   = 1'b1;
                        mem_write        = req1_write;
                        mem_address      = req1_address;
                        mem_byteenable   = req1_byteenable;
                        mem_writedata    = req1_writedata;
                        w_rr_nxt         = 1'b0;
                        w_vld_p0         = ~req1_write;
                        w_id_p0          = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= (INIT_CLEAR != 0) ? S_INIT : S_ARB;
            r_cnt       <= '0;
            r_init_done <= (INIT_CLEAR == 0);
            r_rr        <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_id_p1     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_done <= w_init_done_nxt;
            r_rr        <= w_rr_nxt;
            r_vld_p1    <= w_vld_p0;
            r_id_p1     <= w_id_p0;
        end
    end

    // Read return: RAM data arrives one cycle after the grant.
    assign req0_readdata      = mem_readdata;
    assign req1_readdata      = mem_readdata;
    assign req0_readdatavalid = r_vld_p1 & ~r_id_p1;
    assign req1_readdatavalid = r_vld_p1 &  r_id_p1;
    assign mem_clken          = 1'b1;
    assign init_done          = r_init_done;

    logic [BE_W-1:0] w_be_unused;
    assign w_be_unused = '0;

endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
// Randomized bench for onchip_mem_port_arbiter with a transaction-level reference
// model (word array, rr favourite, pending read) and a one-cycle-latency RAM.
module tb_onchip_mem_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] req0_address, req1_address;
    logic [BW-1:0] req0_byteenable, req1_byteenable;
    logic          req0_read, req0_write, req1_read, req1_write;
    logic [DW-1:0] req0_writedata, req1_writedata;
    logic          req0_waitrequest, req1_waitrequest;
    logic [DW-1:0] req0_readdata, req1_readdata;
    logic          req0_readdatavalid, req1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          init_done;

    onchip_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_CLEAR(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_address(req0_address), .req0_byteenable(req0_byteenable),
        .req0_read(req0_read), .req0_write(req0_write), .req0_writedata(req0_writedata),
        .req0_waitrequest(req0_waitrequest), .req0_readdata(req0_readdata),
        .req0_readdatavalid(req0_readdatavalid),
        .req1_address(req1_address), .req1_byteenable(req1_byteenable),
        .req1_read(req1_read), .req1_write(req1_write), .req1_writedata(req1_writedata),
        .req1_waitrequest(req1_waitrequest), .req1_readdata(req1_readdata),
        .req1_readdatavalid(req1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // RAM s1 port stand-in, seeded with junk so the clear pass matters.
    logic [DW-1:0] fx_ram [DEPTH];
    logic          fx_seeded = 1'b0;
    always @(posedge clk) begin
        if (!fx_seeded) begin
            for (int i = 0; i < DEPTH; i++) fx_ram[i] <= {$urandom(), $urandom()};
            fx_seeded <= 1'b1;
        end
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) fx_ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= fx_ram[mem_address];
            end
        end
    end

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_rdv0, n_rdv1;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init, m_done, m_rr, m_pend, m_pid;
    int            m_cnt;
    int            m_win;
    logic [DW-1:0] m_pdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit            a0, a1;
        logic          ew0, ew1, ecs, emw;
        logic [AW-1:0] ea;
        logic [BW-1:0] ebe;
        logic [DW-1:0] ewd;
        a0 = req0_read | req0_write;
        a1 = req1_read | req1_write;
        m_win = -1;
        ew0 = 1'b1; ew1 = 1'b1; ecs = 1'b0; emw = 1'b0;
        ea = '0; ebe = '0; ewd = '0;
        if (m_init) begin
            ecs = 1'b1; emw = 1'b1; ea = AW'(m_cnt); ebe = '1; ewd = '0;
        end else begin
            if (a0 && a1) m_win = m_rr ? 1 : 0;
            else if (a0)  m_win = 0;
            else if (a1)  m_win = 1;
            if (m_win == 0) begin
                ew0 = 1'b0; ecs = 1'b1; emw = req0_write;
                ea = req0_address; ebe = req0_byteenable; ewd = req0_writedata;
            end else if (m_win == 1) begin
                ew1 = 1'b0; ecs = 1'b1; emw = req1_write;
                ea = req1_address; ebe = req1_byteenable; ewd = req1_writedata;
            end
        end
        chk("wait0", req0_waitrequest, ew0);
        chk("wait1", req1_waitrequest, ew1);
        chk("cs", mem_chipselect, ecs);
        chk("clken", mem_clken, 1'b1);
        chk("init_done", init_done, m_done);
        if (ecs) begin
            chk("mem_write", mem_write, emw);
            chk("mem_addr", mem_address, ea);
            chk("mem_be", mem_byteenable, ebe);
            if (emw) chk("mem_wdata", mem_writedata, ewd);
        end
        chk("rdv0", req0_readdatavalid, m_pend && !m_pid);
        chk("rdv1", req1_readdatavalid, m_pend && m_pid);
        if (m_pend) chk("rdata", m_pid ? req1_readdata : req0_readdata, m_pdata);
        n_rdv0 += int'(req0_readdatavalid);
        n_rdv1 += int'(req1_readdatavalid);
    endtask

    task automatic drive(input logic rd0, input logic wr0, input logic [AW-1:0] a0,
                         input logic [BW-1:0] be0, input logic [DW-1:0] d0,
                         input logic rd1, input logic wr1, input logic [AW-1:0] a1,
                         input logic [BW-1:0] be1, input logic [DW-1:0] d1);
        req0_read = rd0; req0_write = wr0; req0_address = a0; req0_byteenable = be0; req0_writedata = d0;
        req1_read = rd1; req1_write = wr1; req1_address = a1; req1_byteenable = be1; req1_writedata = d1;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic advance();
        logic          wr;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] d;
        if (m_init) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end else begin
                m_cnt++;
            end
            m_pend = 1'b0;
        end else if (m_win >= 0) begin
            wr = (m_win == 0) ? req0_write : req1_write;
            a  = (m_win == 0) ? req0_address : req1_address;
            be = (m_win == 0) ? req0_byteenable : req1_byteenable;
            d  = (m_win == 0) ? req0_writedata : req1_writedata;
            m_rr = (m_win == 0);
            if (wr) begin
                for (int b = 0; b < BW; b++)
                    if (be[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
                m_pend = 1'b0;
            end else begin
                m_pend  = 1'b1;
                m_pid   = (m_win == 1);
                m_pdata = m_mem[a];
            end
        end else begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        advance();
    endtask

    task automatic apply_reset(input int n);
        reset_n = 1'b0;
        m_init = 1'b1; m_done = 1'b0; m_cnt = 0; m_rr = 1'b0; m_pend = 1'b0; m_pid = 1'b0;
        #1;
        chk("rst_rdv0", req0_readdatavalid, 1'b0);
        chk("rst_rdv1", req1_readdatavalid, 1'b0);
        chk("rst_wait0", req0_waitrequest, 1'b1);
        chk("rst_wait1", req1_waitrequest, 1'b1);
        chk("rst_cs", mem_chipselect, 1'b0);
        chk("rst_mw", mem_write, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req0_read = 0; req0_write = 0; req0_address = '0; req0_byteenable = '0; req0_writedata = '0;
        req1_read = 0; req1_write = 0; req1_address = '0; req1_byteenable = '0; req1_writedata = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        @(posedge clk);
        #1;
        apply_reset(3);

        // Clear pass with req0 holding a read of address 5.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 0, AW'(5), '1, '0, 0, 0, '0, '0, '0);
            advance();
            if (k == DEPTH - 2) chk("init_done_pre", init_done, 1'b0);
        end
        chk("init_done_post", init_done, 1'b1);
        drive(1, 0, AW'(5), '1, '0, 0, 0, '0, '0, '0);
        chk("first_grant", req0_waitrequest, 1'b0);
        advance();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        chk("rd5_vld", req0_readdatavalid, 1'b1);
        chk("rd5_data", req0_readdata, 64'h0);
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) drive(1, 0, AW'(i), '1, '0, 0, 0, '0, '0, '0);
            else            drive(0, 0, '0, '0, '0, 1, 0, AW'(i), '1, '0);
            advance();
        end
        idle();

        // Write by req0, read back by req1.
        drive(0, 1, AW'('h10), 8'hFF, 64'h0123456789ABCDEF, 0, 0, '0, '0, '0);
        advance();
        drive(0, 0, '0, '0, '0, 1, 0, AW'('h10), 8'hFF, '0);
        advance();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        chk("xfer_vld1", req1_readdatavalid, 1'b1);
        chk("xfer_vld0", req0_readdatavalid, 1'b0);
        chk("xfer_data", req1_readdata, 64'h0123456789ABCDEF);
        advance();

        // Continuous contention alternates grants.
        n_rdv0 = 0; n_rdv1 = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, AW'(k), '1, '0, 1, 0, AW'(k + 8), '1, '0);
            chk("alt_wait0", req0_waitrequest, (k % 2) == 1);
            advance();
        end
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        advance();
        chk("alt_cnt0", n_rdv0, 3);
        chk("alt_cnt1", n_rdv1, 3);

        // Partial byte-lane write.
        drive(0, 1, AW'('h20), 8'h0F, 64'hFFFFFFFFFFFFFFFF, 0, 0, '0, '0, '0);
        advance();
        drive(1, 0, AW'('h20), 8'hFF, '0, 0, 0, '0, '0, '0);
        advance();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        chk("partial_data", req0_readdata, 64'h00000000FFFFFFFF);
        advance();

        // Read+write together behaves as a write.
        drive(0, 0, '0, '0, '0, 1, 1, AW'(3), 8'hFF, 64'hAA);
        chk("rw_is_write", mem_write, 1'b1);
        advance();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        chk("rw_no_vld", req1_readdatavalid, 1'b0);
        advance();
        drive(0, 0, '0, '0, '0, 1, 0, AW'(3), 8'hFF, '0);
        advance();
        drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        chk("rw_readback", req1_readdata, 64'hAA);
        advance();

        for (int k = 0; k < 600; k++) begin
            int op0, op1;
            op0 = $urandom_range(0, 3);
            op1 = $urandom_range(0, 3);
            drive(op0[0], op0[1], AW'($urandom_range(0, 15)), BW'($urandom()), {$urandom(), $urandom()},
                  op1[0], op1[1], AW'($urandom_range(0, 15)), BW'($urandom()), {$urandom(), $urandom()});
            advance();
        end

        // Reset pulsed while a read is granted.
        drive(1, 0, AW'(7), '1, '0, 0, 0, '0, '0, '0);
        chk("pre_rst_grant", req0_waitrequest, 1'b0);
        #2;
        apply_reset(2);
        drive(1, 0, AW'(7), '1, '0, 0, 0, '0, '0, '0);
        chk("post_rst_vld", req0_readdatavalid, 1'b0);
        chk("restart_addr", mem_address, '0);
        advance();
        for (int k = 1; k < DEPTH + 60; k++) begin
            int op0, op1;
            op0 = $urandom_range(0, 3);
            op1 = $urandom_range(0, 3);
            drive(op0[0], op0[1], AW'($urandom_range(0, 127)), BW'($urandom()), {$urandom(), $urandom()},
                  op1[0], op1[1], AW'($urandom_range(0, 127)), BW'($urandom()), {$urandom(), $urandom()});
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
